mips_cpu_bus_ctrl: RTL

Avalon memory-mapped bus controller that shares the single CPU bus master between two requesters: instruction fetch and data load/store. It arbitrates between them and sequences each transaction through waitrequest stalls and the fixed one-cycle read latency. For data accesses it generates byteenable, lane-shifted writedata and sign/zero-extended read results for byte, half and word sizes. It sits between the CPU state machine and the top-level bus ports.

---
 rtl/mips_cpu_pkg.sv | 38 +++
 rtl/mips_cpu_lane_align.sv | 56 +++++
 rtl/mips_cpu_bus_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU Avalon bus controller: access sizes,
// controller states, bus owners and the command latched at grant.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RDATA = 2'b10,
    S_DONE  = 2'b11
  } typeBusState;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Only the fields still needed after the bus cycle is issued are kept;
  // address, direction and store data live in the bus output registers.
  typedef struct packed {
    owner_e      owner;
    size_e       size;
    logic        sgn;
    logic [1:0]  addr_lo;
  } bus_cmd_t;

  // Avalon word address: byte offset bits forced to zero.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_cpu_lane_align.sv
// Little-endian byte-lane steering: byteenable and shifted store data for a
// request, lane extraction plus sign/zero extension for load data, and the
// alignment / reserved-size fault check.
module mips_cpu_lane_align
  import mips_cpu_pkg::*;
(
  input  size_e        size_i,
  input  logic [1:0]   addr_i,
  input  logic         signed_i,
  input  logic [31:0]  wdata_i,
  input  logic [31:0]  rdata_i,
  output logic [3:0]   be_o,
  output logic [31:0]  wdata_o,
  output logic [31:0]  rdata_o,
  output logic         fault_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane decode per access size; word ignores the offset for data steering.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0000_0000;
    rdata_o = 32'h0000_0000;
    fault_o = 1'b0;
    byte_s  = 8'(rdata_i >> {addr_i, 3'b000});
    half_s  = 16'(rdata_i >> {addr_i[1], 4'b0000});
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {24'h00_0000, wdata_i[7:0]} << {addr_i, 3'b000};
        rdata_o = {{24{signed_i & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {16'h0000, wdata_i[15:0]} << {addr_i[1], 4'b0000};
        rdata_o = {{16{signed_i & half_s[15]}}, half_s};
        fault_o = addr_i[0];
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        fault_o = (addr_i != 2'b00);
      end
      SZ_RSVD: begin
        fault_o = 1'b1;
      end
      default: begin
        fault_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_ctrl.sv
// Avalon-MM bus controller shared by instruction fetch and data load/store.
// Data wins simultaneous requests; each transaction runs IDLE -> ISSUE ->
// (RDATA) -> DONE, or IDLE -> DONE on a misaligned/reserved data access.
module mips_cpu_bus_ctrl
  import mips_cpu_pkg::*;
#(
  parameter logic [3:0] RESET_BE = 4'b0000
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         fetch_req_i,
  input  logic [31:0]  fetch_addr_i,
  output logic         fetch_done_o,
  output logic [31:0]  fetch_rdata_o,
  input  logic         data_req_i,
  input  logic         data_we_i,
  input  logic [1:0]   data_size_i,
  input  logic         data_signed_i,
  input  logic [31:0]  data_addr_i,
  input  logic [31:0]  data_wdata_i,
  output logic         data_done_o,
  output logic [31:0]  data_rdata_o,
  output logic         data_fault_o,
  output logic         busy_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         waitrequest_i,
  output logic [31:0]  writedata_o,
  output logic [3:0]   byteenable_o,
  input  logic [31:0]  readdata_i
);

  typeBusState  state_q;
  bus_cmd_t     cmd_q;
  logic         read_q;
  logic         write_q;
  logic [31:0]  address_q;
  logic [31:0]  writedata_q;
  logic [3:0]   byteenable_q;
  logic         fetch_done_q;
  logic [31:0]  fetch_rdata_q;
  logic         data_done_q;
  logic [31:0]  data_rdata_q;
  logic         data_fault_q;

  size_e        la_size_d;
  logic [1:0]   la_addr_d;
  logic         la_sgn_d;
  logic [31:0]  la_wdata_d;
  logic [3:0]   la_be_s;
  logic [31:0]  la_wdata_s;
  logic [31:0]  la_rdata_s;
  logic         la_fault_s;

  // Lane aligner sees the incoming request while idle, the latched command otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      if (data_req_i) begin
        la_size_d  = size_e'(data_size_i);
        la_addr_d  = data_addr_i[1:0];
        la_sgn_d   = data_signed_i;
        la_wdata_d = data_wdata_i;
      end else begin
        la_size_d  = SZ_WORD;
        la_addr_d  = 2'b00;
        la_sgn_d   = 1'b0;
        la_wdata_d = 32'h0000_0000;
      end
    end else begin
      la_size_d  = cmd_q.size;
      la_addr_d  = cmd_q.addr_lo;
      la_sgn_d   = cmd_q.sgn;
      la_wdata_d = 32'h0000_0000;
    end
  end

  mips_cpu_lane_align u_lane_align (
    .size_i   (la_size_d),
    .addr_i   (la_addr_d),
    .signed_i (la_sgn_d),
    .wdata_i  (la_wdata_d),
    .rdata_i  (readdata_i),
    .be_o     (la_be_s),
    .wdata_o  (la_wdata_s),
    .rdata_o  (la_rdata_s),
    .fault_o  (la_fault_s)
  );

  // Transaction sequencer with registered bus and requester outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      cmd_q         <= '{owner: OWN_FETCH, size: SZ_BYTE, sgn: 1'b0, addr_lo: 2'b00};
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= 32'h0000_0000;
      writedata_q   <= 32'h0000_0000;
      byteenable_q  <= RESET_BE;
      fetch_done_q  <= 1'b0;
      fetch_rdata_q <= 32'h0000_0000;
      data_done_q   <= 1'b0;
      data_rdata_q  <= 32'h0000_0000;
      data_fault_q  <= 1'b0;
    end else begin
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      data_fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (data_req_i) begin
            cmd_q <= '{owner: OWN_DATA, size: la_size_d, sgn: data_signed_i,
                       addr_lo: data_addr_i[1:0]};
            if (la_fault_s) begin
              // Faulting access never reaches the bus.
              state_q      <= S_DONE;
              data_done_q  <= 1'b1;
              data_fault_q <= 1'b1;
              data_rdata_q <= 32'h0000_0000;
            end else begin
              state_q      <= S_ISSUE;
              address_q    <= word_addr(data_addr_i);
              read_q       <= ~data_we_i;
              write_q      <= data_we_i;
              byteenable_q <= la_be_s;
              writedata_q  <= la_wdata_s;
            end
          end else if (fetch_req_i) begin
            cmd_q <= '{owner: OWN_FETCH, size: SZ_WORD, sgn: 1'b0,
                       addr_lo: fetch_addr_i[1:0]};
            state_q      <= S_ISSUE;
            address_q    <= word_addr(fetch_addr_i);
            read_q       <= 1'b1;
            write_q      <= 1'b0;
            byteenable_q <= la_be_s;
          end else begin
            byteenable_q <= RESET_BE;
          end
        end
        S_ISSUE: begin
          if (!waitrequest_i) begin
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= RESET_BE;
            if (write_q) begin
              state_q     <= S_DONE;
              data_done_q <= 1'b1;
            end else begin
              state_q <= S_RDATA;
            end
          end else begin
            state_q <= S_ISSUE;
          end
        end
        S_RDATA: begin
          if (cmd_q.owner == OWN_FETCH) begin
            fetch_rdata_q <= readdata_i;
            fetch_done_q  <= 1'b1;
          end else begin
            data_rdata_q <= la_rdata_s;
            data_done_q  <= 1'b1;
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign address_o     = address_q;
  assign read_o        = read_q;
  assign write_o       = write_q;
  assign writedata_o   = writedata_q;
  assign byteenable_o  = byteenable_q;
  assign fetch_done_o  = fetch_done_q;
  assign fetch_rdata_o = fetch_rdata_q;
  assign data_done_o   = data_done_q;
  assign data_rdata_o  = data_rdata_q;
  assign data_fault_o  = data_fault_q;

endmodule
